riscv_i32_dmem_responder: RTL

- Slave end of the dmem access interface: accepts dmem_access_req from the core, returns dmem_access_resp (ack, ack_if_seq, abort_req, read_data_valid, read_data).
- Backs accesses with a byte-enabled word SRAM and configurable wait states.
- Its read_data feeds the core's dmem read-data alignment/sign-extension path, which does rotation and sign extension. The responder returns raw aligned 32-bit words only.

---
 rtl/riscv_dmem_pkg.sv | 29 ++
 rtl/riscv_i32_dmem_sram_be.sv | 34 +++
 rtl/riscv_i32_dmem_responder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/riscv_dmem_pkg.sv
// rtl/riscv_dmem_pkg.sv - shared request types, field widths and wait-counter width for the dmem responder
package riscv_dmem_pkg;

    // Request/response field widths
    localparam int DMEM_REQ_TYPE_W = 5;
    localparam int DMEM_ADDR_W     = 32;
    localparam int DMEM_DATA_W     = 32;
    localparam int DMEM_BE_W       = 4;

    // Wait-state counter width (WAIT_STATES is limited to 0..15)
    localparam int WAIT_CNT_W = 4;

    // Access types carried in req_type; anything else is unsupported
    localparam logic [DMEM_REQ_TYPE_W-1:0] DMEM_REQ_NONE  = 5'h00;
    localparam logic [DMEM_REQ_TYPE_W-1:0] DMEM_REQ_READ  = 5'h01;
    localparam logic [DMEM_REQ_TYPE_W-1:0] DMEM_REQ_WRITE = 5'h02;

    // IDLE means the wait counter is zero and the responder is ready
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } wait_state_e;

    // True for the access types the responder can service
    function automatic logic is_supported_type(input logic [DMEM_REQ_TYPE_W-1:0] req_type);
        return (req_type == DMEM_REQ_READ) || (req_type == DMEM_REQ_WRITE);
    endfunction

endpackage

// File: rtl/riscv_i32_dmem_sram_be.sv
// rtl/riscv_i32_dmem_sram_be.sv - single-port word SRAM with byte-lane write enables and registered read
module riscv_i32_dmem_sram_be
    import riscv_dmem_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1
) (
    input  logic                   clk,
    input  logic                   en,
    input  logic                   we,
    input  logic [DMEM_BE_W-1:0]   be,
    input  logic [IDX_W-1:0]       addr,
    input  logic [DMEM_DATA_W-1:0] wdata,
    output logic [DMEM_DATA_W-1:0] rdata
);

    logic [DMEM_DATA_W-1:0] mem [MEM_WORDS];

    // Lane-masked write, or capture the addressed word for a read; contents are never reset
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < DMEM_BE_W; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/riscv_i32_dmem_responder.sv
// rtl/riscv_i32_dmem_responder.sv - dmem access slave: wait-state FSM, decode/abort and registered read return
module riscv_i32_dmem_responder
    import riscv_dmem_pkg::*;
#(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       dmem_access_req__valid,
    input  logic [DMEM_REQ_TYPE_W-1:0] dmem_access_req__req_type,
    input  logic [DMEM_ADDR_W-1:0]     dmem_access_req__address,
    input  logic                       dmem_access_req__sequential,
    input  logic [DMEM_BE_W-1:0]       dmem_access_req__byte_enable,
    input  logic [DMEM_DATA_W-1:0]     dmem_access_req__write_data,
    output logic                       dmem_access_resp__ack_if_seq,
    output logic                       dmem_access_resp__ack,
    output logic                       dmem_access_resp__abort_req,
    output logic                       dmem_access_resp__read_data_valid,
    output logic [DMEM_DATA_W-1:0]     dmem_access_resp__read_data
);

    localparam int                    IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);
    localparam logic                  NO_WAIT   = (WAIT_STATES == 0);

    wait_state_e             state;
    wait_state_e             state_next;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic [WAIT_CNT_W-1:0]   wait_cnt_next;
    // Set for the single IDLE cycle after the wait count expires, so the held
    // non-sequential request is answered instead of restarting the wait.
    logic                    primed;
    logic                    primed_next;

    logic [DMEM_ADDR_W-3:0]  word_idx;
    logic                    in_range;
    logic                    aligned;
    logic                    legal;
    logic                    is_read;
    logic                    is_write;
    logic                    ready;
    logic                    respond;

    logic                    sram_en;
    logic                    sram_we;
    logic [DMEM_DATA_W-1:0]  sram_rdata;
    logic                    read_valid_q;

    assign word_idx = dmem_access_req__address[DMEM_ADDR_W-1:2];
    assign in_range = ({2'b00, word_idx} < DMEM_ADDR_W'(MEM_WORDS));
    assign aligned  = (dmem_access_req__address[1:0] == 2'b00);
    assign is_read  = (dmem_access_req__req_type == DMEM_REQ_READ);
    assign is_write = (dmem_access_req__req_type == DMEM_REQ_WRITE);
    assign legal    = is_supported_type(dmem_access_req__req_type) && aligned && in_range;

    assign ready    = (state == ST_IDLE);
    assign respond  = ready && dmem_access_req__valid &&
                      (dmem_access_req__sequential || NO_WAIT || primed);

    // State register: wait FSM state, countdown and the post-wait grant flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            primed   <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            primed   <= primed_next;
        end
    end

    // Next-state logic: start a wait for a fresh non-sequential request, count down while it is held
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        primed_next   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dmem_access_req__valid && !dmem_access_req__sequential && !NO_WAIT && !primed) begin
                    wait_cnt_next = WAIT_LOAD;
                    state_next    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!dmem_access_req__valid) begin
                    // Withdrawn request: abandon the wait without any response
                    wait_cnt_next = '0;
                    state_next    = ST_IDLE;
                end else begin
                    wait_cnt_next = wait_cnt - 1'b1;
                    if (wait_cnt == WAIT_CNT_W'(1)) begin
                        state_next  = ST_IDLE;
                        primed_next = 1'b1;
                    end
                end
            end
            default: begin
                wait_cnt_next = '0;
                state_next    = ST_IDLE;
            end
        endcase
    end

    // Output logic: ack/abort on the respond cycle and SRAM strobes for acked accesses
    always_comb begin
        dmem_access_resp__ack_if_seq = ready;
        dmem_access_resp__ack        = respond && legal;
        dmem_access_resp__abort_req  = respond && !legal;
        sram_en                      = respond && legal;
        sram_we                      = respond && legal && is_write;
    end

    // Read-return flag: high the cycle after a read ack, cleared asynchronously by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_valid_q <= 1'b0;
        end else begin
            read_valid_q <= respond && legal && is_read;
        end
    end

    assign dmem_access_resp__read_data_valid = read_valid_q;
    assign dmem_access_resp__read_data       = read_valid_q ? sram_rdata : '0;

    riscv_i32_dmem_sram_be #(
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IDX_W)
    ) u_sram (
        .clk   (clk),
        .en    (sram_en),
        .we    (sram_we),
        .be    (dmem_access_req__byte_enable),
        .addr  (word_idx[IDX_W-1:0]),
        .wdata (dmem_access_req__write_data),
        .rdata (sram_rdata)
    );

endmodule
